// File: rtl/riscv_defines.sv
// ---------------------------------------------------------------------------
// riscv_defines
//   Shared constants for the core datapath: ALU operation encodings and the
//   tag-check policy encodings held in the Tag Check Register.
//   No ports; imported by the datapath and tag-check blocks.
// ---------------------------------------------------------------------------
package riscv_defines;

    // ALU operation encodings
    localparam int unsigned ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 7'b0000001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 7'b0001101;

    // Tag-check policy encodings
    localparam int unsigned CHECK_MODE_WIDTH = 3;

    localparam logic [CHECK_MODE_WIDTH-1:0] CHECK_MODE_OFF = 3'd0; // never flag
    localparam logic [CHECK_MODE_WIDTH-1:0] CHECK_MODE_A   = 3'd1; // operand A tagged
    localparam logic [CHECK_MODE_WIDTH-1:0] CHECK_MODE_B   = 3'd2; // operand B tagged
    localparam logic [CHECK_MODE_WIDTH-1:0] CHECK_MODE_AB  = 3'd3; // either operand tagged
    localparam logic [CHECK_MODE_WIDTH-1:0] CHECK_MODE_RES = 3'd4; // result tagged

endpackage : riscv_defines

// File: rtl/riscv_tag_check_decode.sv
// ---------------------------------------------------------------------------
// riscv_tag_check_decode
//   Purely combinational policy decode: given the active check mode and the
//   operand/result tags, says whether this instruction violates the policy.
//   Unknown mode encodings never flag, so a misprogrammed register fails open
//   rather than wedging the pipeline with spurious exceptions.
//
//   Ports:
//     check_mode_i  policy from the Tag Check Register
//     tag_a_i       source operand A tag
//     tag_b_i       source operand B tag
//     tag_result_i  destination tag from the tag ALU
//     violation_o   1 when the selected tags indicate a violation
// ---------------------------------------------------------------------------
module riscv_tag_check_decode
    import riscv_defines::*;
(
    input  logic [CHECK_MODE_WIDTH-1:0] check_mode_i,
    input  logic                        tag_a_i,
    input  logic                        tag_b_i,
    input  logic                        tag_result_i,
    output logic                        violation_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives violation_o and
        // no latch is inferred.
        violation_o = 1'b0;
        unique case (check_mode_i)
            CHECK_MODE_OFF: violation_o = 1'b0;
            CHECK_MODE_A:   violation_o = tag_a_i;
            CHECK_MODE_B:   violation_o = tag_b_i;
            CHECK_MODE_AB:  violation_o = tag_a_i | tag_b_i;
            CHECK_MODE_RES: violation_o = tag_result_i;
            default:        violation_o = 1'b0;
        endcase
    end

endmodule : riscv_tag_check_decode

// File: rtl/riscv_tag_check_unit.sv
// ---------------------------------------------------------------------------
// riscv_tag_check_unit
//   Tag security check for the EX stage. An enabled, valid check whose policy
//   decode flags a violation raises a tag exception request (one cycle later),
//   captures the faulting PC and holds the pipeline until the controller
//   acknowledges. Violations are counted in a saturating counter.
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     enable_i         global tag-check enable
//     check_valid_i    instruction in EX requests a tag check
//     check_mode_i     check policy
//     tag_a_i/tag_b_i  source operand tags
//     tag_result_i     destination tag
//     pc_i             PC of the checked instruction
//     exc_ack_i        controller accepts the pending exception
//     cnt_clear_i      synchronous clear of the violation counter
//     exc_req_o        tag exception request (high while pending)
//     exc_pc_o         PC of the most recent faulting instruction
//     stall_o          pipeline hold (high while pending)
//     violation_cnt_o  saturating violation count
// ---------------------------------------------------------------------------
module riscv_tag_check_unit
    import riscv_defines::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic                        check_valid_i,
    input  logic [CHECK_MODE_WIDTH-1:0] check_mode_i,
    input  logic                        tag_a_i,
    input  logic                        tag_b_i,
    input  logic                        tag_result_i,
    input  logic [PC_WIDTH-1:0]         pc_i,
    input  logic                        exc_ack_i,
    input  logic                        cnt_clear_i,
    output logic                        exc_req_o,
    output logic [PC_WIDTH-1:0]         exc_pc_o,
    output logic                        stall_o,
    output logic [CNT_WIDTH-1:0]        violation_cnt_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t               state_q;
    logic [PC_WIDTH-1:0]  exc_pc_q;
    logic [CNT_WIDTH-1:0] violation_cnt_q;

    logic violation;
    logic raise;

    riscv_tag_check_decode u_decode (
        .check_mode_i (check_mode_i),
        .tag_a_i      (tag_a_i),
        .tag_b_i      (tag_b_i),
        .tag_result_i (tag_result_i),
        .violation_o  (violation)
    );

    // A check is only considered while idle; anything arriving while an
    // exception is outstanding (including the ack cycle) is dropped.
    assign raise = (state_q == IDLE) && check_valid_i && enable_i && violation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments throughout this block so every
            // register samples the pre-edge values of the others.
            state_q         <= IDLE;
            exc_pc_q        <= '0;
            violation_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (raise) begin
                        state_q  <= PENDING;
                        exc_pc_q <= pc_i;
                    end
                end
                PENDING: begin
                    // enable_i is deliberately not consulted: disabling checks
                    // must not silently cancel an outstanding exception.
                    if (exc_ack_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Clear wins over a coincident violation.
            if (cnt_clear_i) begin
                violation_cnt_q <= '0;
            end else if (raise && (violation_cnt_q != {CNT_WIDTH{1'b1}})) begin
                violation_cnt_q <= violation_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Request and stall are direct decodes of the state flop, so both are
    // glitch-free and rise exactly one cycle after the violating edge.
    assign exc_req_o       = (state_q == PENDING);
    assign stall_o         = (state_q == PENDING);
    assign exc_pc_o        = exc_pc_q;
    assign violation_cnt_o = violation_cnt_q;

endmodule : riscv_tag_check_unit

// File: tb/tb_riscv_tag_check_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_tag_check_unit
//   Directed bench for riscv_tag_check_unit. Each step drives one cycle of
//   inputs, advances a reference model of the expected behaviour, pushes the
//   model's predicted outputs into a queue and pops/compares them once the
//   DUT has clocked.
// ---------------------------------------------------------------------------
module tb_riscv_tag_check_unit;
    import riscv_defines::*;

    localparam int unsigned PC_WIDTH  = 32;
    localparam int unsigned CNT_WIDTH = 16;

    logic                        clk;
    logic                        rst_n;
    logic                        enable_i;
    logic                        check_valid_i;
    logic [CHECK_MODE_WIDTH-1:0] check_mode_i;
    logic                        tag_a_i;
    logic                        tag_b_i;
    logic                        tag_result_i;
    logic [PC_WIDTH-1:0]         pc_i;
    logic                        exc_ack_i;
    logic                        cnt_clear_i;
    logic                        exc_req_o;
    logic [PC_WIDTH-1:0]         exc_pc_o;
    logic                        stall_o;
    logic [CNT_WIDTH-1:0]        violation_cnt_o;

    riscv_tag_check_unit #(
        .PC_WIDTH  (PC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .check_valid_i   (check_valid_i),
        .check_mode_i    (check_mode_i),
        .tag_a_i         (tag_a_i),
        .tag_b_i         (tag_b_i),
        .tag_result_i    (tag_result_i),
        .pc_i            (pc_i),
        .exc_ack_i       (exc_ack_i),
        .cnt_clear_i     (cnt_clear_i),
        .exc_req_o       (exc_req_o),
        .exc_pc_o        (exc_pc_o),
        .stall_o         (stall_o),
        .violation_cnt_o (violation_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 req;
        logic                 stall;
        logic [PC_WIDTH-1:0]  pc;
        logic [CNT_WIDTH-1:0] cnt;
    } expect_t;

    expect_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic                 m_pend;
    logic [PC_WIDTH-1:0]  m_pc;
    logic [CNT_WIDTH-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic model_violation(input logic [2:0] mode, input logic a,
                                             input logic b, input logic r);
        case (mode)
            3'd1:    return a;
            3'd2:    return b;
            3'd3:    return a | b;
            3'd4:    return r;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_pc   = '0;
        m_cnt  = '0;
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare.
    task automatic step(input string tag, input logic valid, input logic en,
                        input logic [2:0] mode, input logic a, input logic b,
                        input logic r, input logic [31:0] pc,
                        input logic ack, input logic clr);
        expect_t e;
        expect_t got;
        logic    raise;
        check_valid_i = valid;
        enable_i      = en;
        check_mode_i  = mode;
        tag_a_i       = a;
        tag_b_i       = b;
        tag_result_i  = r;
        pc_i          = pc;
        exc_ack_i     = ack;
        cnt_clear_i   = clr;

        raise = !m_pend && valid && en && model_violation(mode, a, b, r);
        if (clr)
            m_cnt = '0;
        else if (raise && m_cnt != 16'hFFFF)
            m_cnt = m_cnt + 16'd1;
        if (raise) begin
            m_pend = 1'b1;
            m_pc   = pc;
        end else if (m_pend && ack) begin
            m_pend = 1'b0;
        end
        e.req = m_pend; e.stall = m_pend; e.pc = m_pc; e.cnt = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".req"},   {31'd0, exc_req_o},       {31'd0, got.req});
        check({tag, ".stall"}, {31'd0, stall_o},         {31'd0, got.stall});
        check({tag, ".pc"},    exc_pc_o,                 got.pc);
        check({tag, ".cnt"},   {16'd0, violation_cnt_o}, {16'd0, got.cnt});
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b1, CHECK_MODE_OFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic ack_step(input string tag);
        step(tag, 1'b0, 1'b1, CHECK_MODE_OFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        enable_i      = 1'b0;
        check_valid_i = 1'b0;
        check_mode_i  = CHECK_MODE_OFF;
        tag_a_i       = 1'b0;
        tag_b_i       = 1'b0;
        tag_result_i  = 1'b0;
        pc_i          = '0;
        exc_ack_i     = 1'b0;
        cnt_clear_i   = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("rst.req",   {31'd0, exc_req_o},       32'd0);
        check("rst.stall", {31'd0, stall_o},         32'd0);
        check("rst.pc",    exc_pc_o,                 32'd0);
        check("rst.cnt",   {16'd0, violation_cnt_o}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mode AB violation, then a second violation while pending, ack 3 cycles later
        step("ab_viol", 1'b1, 1'b1, CHECK_MODE_AB, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        check("ab_viol.req_const", {31'd0, exc_req_o}, 32'd1);
        check("ab_viol.pc_const",  exc_pc_o,           32'h0000_0100);
        check("ab_viol.cnt_const", {16'd0, violation_cnt_o}, 32'd1);
        step("pend_viol", 1'b1, 1'b1, CHECK_MODE_A, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        check("pend_viol.pc_const", exc_pc_o, 32'h0000_0100);
        step("pend_disable", 1'b0, 1'b0, CHECK_MODE_OFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ack_step("ack1");
        check("ack1.req_const", {31'd0, exc_req_o}, 32'd0);

        // Ack while idle is ignored; disabled / OFF / unknown modes never flag
        ack_step("idle_ack");
        step("dis_res", 1'b1, 1'b0, CHECK_MODE_RES, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        step("off_all", 1'b1, 1'b1, CHECK_MODE_OFF, 1'b1, 1'b1, 1'b1, 32'h0000_0304, 1'b0, 1'b0);
        for (int m = 5; m < 8; m++)
            step("bad_mode", 1'b1, 1'b1, 3'(m), 1'b1, 1'b1, 1'b1, 32'h0000_0308, 1'b0, 1'b0);
        step("a_clean", 1'b1, 1'b1, CHECK_MODE_A, 1'b0, 1'b1, 1'b1, 32'h0000_030C, 1'b0, 1'b0);
        step("res_clean", 1'b1, 1'b1, CHECK_MODE_RES, 1'b1, 1'b1, 1'b0, 32'h0000_0310, 1'b0, 1'b0);
        check("clean.pc_const", exc_pc_o, 32'h0000_0100);

        // Mode B violation; a violation coinciding with the ack is dropped
        step("b_viol", 1'b1, 1'b1, CHECK_MODE_B, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0);
        step("ack_viol", 1'b1, 1'b1, CHECK_MODE_B, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 1'b1, 1'b0);
        step("res_viol", 1'b1, 1'b1, CHECK_MODE_RES, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        ack_step("ack_res");
        check("res.cnt_const", {16'd0, violation_cnt_o}, 32'd3);

        // Clear without a violation
        step("clear", 1'b0, 1'b1, CHECK_MODE_OFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Saturation: preload the counter near full
        force dut.violation_cnt_q = 16'hFFFE;
        #1 release dut.violation_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            step("sat_viol", 1'b1, 1'b1, CHECK_MODE_AB, 1'b0, 1'b1, 1'b0, 32'h0000_0600 + 32'(i), 1'b0, 1'b0);
            ack_step("sat_ack");
        end
        check("sat.cnt_const", {16'd0, violation_cnt_o}, 32'h0000_FFFF);

        // Clear coinciding with a violation
        step("clr_viol", 1'b1, 1'b1, CHECK_MODE_A, 1'b1, 1'b0, 1'b0, 32'h0000_0700, 1'b0, 1'b1);
        check("clr_viol.cnt_const", {16'd0, violation_cnt_o}, 32'd0);
        check("clr_viol.req_const", {31'd0, exc_req_o},       32'd1);
        ack_step("clr_ack");

        // Reset while pending
        step("pre_rst", 1'b1, 1'b1, CHECK_MODE_RES, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("prst.req",   {31'd0, exc_req_o},       32'd0);
        check("prst.stall", {31'd0, stall_o},         32'd0);
        check("prst.pc",    exc_pc_o,                 32'd0);
        check("prst.cnt",   {16'd0, violation_cnt_o}, 32'd0);
        model_reset();
        check_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b1, CHECK_MODE_AB, 1'b0, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 1'b0);
        check("post_rst.pc_const", exc_pc_o, 32'h0000_0900);
        ack_step("post_ack");
        idle("final");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_riscv_tag_check_unit
